// File: rtl/bus_master_if.sv
// Requester-side bus interface: one client access -> arbitrated, strobed bus transfer.
// Optional BUS_TIMEOUT_EN builds a REQ/XFER watchdog that aborts with cpu_err.
module bus_master_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [SEL_W-1:0]  cpu_sel,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              bus_req,
    input  logic              bus_get,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [SEL_W-1:0]  bus_sel,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    if (SEL_W != DATA_W / 8 || TIMEOUT < 1) begin : g_bad_params
        $error("bus_master_if: SEL_W must equal DATA_W/8 and TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StGap} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [SEL_W-1:0]  r_bus_sel;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_ready;
    logic              w_accept;
    logic              w_stb;
    logic              w_done;
    logic              w_expire;

    assign w_accept = (r_state == StIdle) && cpu_req;
    // Strobe only while the grant is actually held; a dropped grant stalls the transfer.
    assign w_stb    = (r_state == StXfer) && bus_get;
    assign w_done   = w_stb && bus_ack;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_cpu_err;

    // Expiry on the edge that would bring the count to TIMEOUT; a same-edge ack wins.
    assign w_expire = ((r_state == StReq) || (r_state == StXfer)) &&
                      (r_cnt == CNT_W'(TIMEOUT - 1)) && !w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_cpu_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
            end else if ((r_state == StReq) || (r_state == StXfer)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_cpu_err <= 1'b0;
            end else if (w_expire) begin
                r_cpu_err <= 1'b1;
            end
        end
    end

    assign cpu_err = r_cpu_err;
`else
    assign w_expire = 1'b0;
    assign cpu_err  = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (cpu_req) begin
                    w_state_next = StReq;
                end
            end
            StReq: begin
                if (w_expire) begin
                    w_state_next = StGap;
                end else if (bus_get) begin
                    w_state_next = StXfer;
                end
            end
            StXfer: begin
                if (w_done || w_expire) begin
                    w_state_next = StGap;
                end
            end
            StGap: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_sel   <= '0;
            r_cpu_rdata <= '0;
            r_cpu_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_ready <= w_done || w_expire;
            if (w_accept) begin
                r_bus_we    <= cpu_we;
                r_bus_addr  <= cpu_addr;
                r_bus_wdata <= cpu_wdata;
                r_bus_sel   <= cpu_sel;
            end
            if (w_done && !r_bus_we) begin
                r_cpu_rdata <= bus_rdata;
            end
        end
    end

    assign bus_req   = (r_state == StReq) || (r_state == StXfer);
    assign bus_stb   = w_stb;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_sel   = r_bus_sel;
    assign cpu_ready = r_cpu_ready;
    assign cpu_rdata = r_cpu_rdata;

endmodule
